// File: rtl/top.sv
// Board top: signed 8x8 radix-2 Booth multiplier with a button start, LED product and 8-digit hex scan.
// Optional macro DEBOUNCE_EN inserts the button debounce filter; otherwise LED_pb is the synchronizer output.
module top #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_CYCLES  = 100000
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        pb_entrada,
    output logic [15:0] LED,
    output logic        LED_reset,
    output logic        LED_pb,
    output logic [7:0]  anodo,
    output logic [6:0]  catodo
);

    // state | meaning
    // IDLE  | waiting for a start pulse; operands captured on it
    // CALC  | one Booth iteration per clock, 8 in total
    // DONE  | product written to LED, back to IDLE
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int RW = $clog2(REFRESH_CYCLES) + 1;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, pb_lvl, pb_prev_q, start;
    logic [8:0]    m_q, m_d, acc_q, acc_d, sum;
    logic [7:0]    q_q, q_d;
    logic          q1_q, q1_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   led_q, led_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    anodo_q, anodo_d;
    logic [6:0]    catodo_q, catodo_d;
    logic [3:0]    digit;

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pb_entrada;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DBW-1:0] DB_RELOAD = DBW'(DEBOUNCE_CYCLES - 1);
    logic [DBW-1:0] db_cnt_q;
    logic           db_lvl_q;

    // Down-counter armed while the input agrees; a new level is taken after DEBOUNCE_CYCLES disagreeing samples.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            db_cnt_q <= DB_RELOAD;
            db_lvl_q <= 1'b0;
        end else if (sync2_q == db_lvl_q) begin
            db_cnt_q <= DB_RELOAD;
        end else if (db_cnt_q == '0) begin
            db_lvl_q <= sync2_q;
            db_cnt_q <= DB_RELOAD;
        end else begin
            db_cnt_q <= db_cnt_q - 1'b1;
        end
    end
    assign pb_lvl = db_lvl_q;
`else
    assign pb_lvl = sync2_q;
`endif

    assign start     = pb_lvl & ~pb_prev_q;
    assign LED_pb    = pb_lvl;
    assign LED_reset = ~reset;
    assign LED       = led_q;
    assign anodo     = anodo_q;
    assign catodo    = catodo_q;

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            pb_prev_q <= 1'b0;
            state_q   <= IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            led_q     <= '0;
            ref_cnt_q <= '0;
            idx_q     <= '0;
            anodo_q   <= 8'b1111_1110;
            catodo_q  <= 7'b1000000;
        end else begin
            pb_prev_q <= pb_lvl;
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            anodo_q   <= anodo_d;
            catodo_q  <= catodo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        sum     = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {A[7], A};
                    q_d     = B;
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                case ({q_q[0], q1_q})
                    2'b01:   sum = acc_q + m_q;
                    2'b10:   sum = acc_q - m_q;
                    default: sum = acc_q;
                endcase
                // Arithmetic shift of {Acc,Q,Q_1}; the 9th Acc bit keeps (-128)*(-128) exact.
                acc_d = {sum[8], sum[8:1]};
                q_d   = {sum[0], q_q[7:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) state_d = DONE;
            end
            DONE: begin
                led_d   = {acc_q[7:0], q_q};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Anode and cathode are both registered from the next index so they switch on the same edge.
    always_comb begin
        ref_cnt_d = ref_cnt_q + RW'(1);
        idx_d     = idx_q;
        if (ref_cnt_q == RW'(REFRESH_CYCLES - 1)) begin
            ref_cnt_d = '0;
            idx_d     = idx_q + 3'd1;
        end
        case (idx_d)
            3'd7:    digit = A[7:4];
            3'd6:    digit = A[3:0];
            3'd5:    digit = B[7:4];
            3'd4:    digit = B[3:0];
            3'd3:    digit = led_q[15:12];
            3'd2:    digit = led_q[11:8];
            3'd1:    digit = led_q[7:4];
            default: digit = led_q[3:0];
        endcase
        anodo_d  = ~(8'b0000_0001 << idx_d);
        catodo_d = hex7(digit);
    end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top (default build, no debounce): products against a signed-multiply model, display against a time-based scan model.
module tb_top;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a, b;
    logic        pb;
    logic [15:0] led;
    logic        led_reset, led_pb;
    logic [7:0]  anodo;
    logic [6:0]  catodo;

    int          total = 0;
    int          bad = 0;
    int          tcount = 0;
    logic [15:0] exp_led = 16'h0000;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    top #(.REFRESH_CYCLES(4)) dut (
        .CLK100MHZ (clk),
        .reset     (rst_n),
        .A         (a),
        .B         (b),
        .pb_entrada(pb),
        .LED       (led),
        .LED_reset (led_reset),
        .LED_pb    (led_pb),
        .anodo     (anodo),
        .catodo    (catodo)
    );

    // clock edges since reset release: the scan position is a pure function of this
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcount = 0;
        else        tcount = tcount + 1;
    end

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = $signed(x) * $signed(y);
        return p[15:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one-clock press; start at edge 3 after it (N), product visible after edge 12 (N+9)
    task automatic do_mult(input logic [7:0] x, input logic [7:0] y, input string name);
        logic [15:0] want;
        want = ref_mul(x, y);
        a = x; b = y;
        pb = 1'b1;
        tick(1);
        pb = 1'b0;
        tick(1);
        total++;
        if (led_pb !== 1'b1) begin bad++; $display("FAIL %s led_pb: got %b want 1", name, led_pb); end
        tick(9);
        total++;
        if (led !== exp_led) begin bad++; $display("FAIL %s early: got %h want %h", name, led, exp_led); end
        tick(1);
        exp_led = want;
        total++;
        if (led !== exp_led) begin bad++; $display("FAIL %s product: got %h want %h", name, led, exp_led); end
        total++;
        if (led_reset !== 1'b0) begin bad++; $display("FAIL %s led_reset: got %b want 0", name, led_reset); end
        tick(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a = 8'h00; b = 8'h00; pb = 1'b0;
        #12;
        total++;
        if (led !== 16'h0000) begin bad++; $display("FAIL reset led: got %h want 0000", led); end
        total++;
        if (led_pb !== 1'b0) begin bad++; $display("FAIL reset led_pb: got %b want 0", led_pb); end
        total++;
        if (anodo !== 8'hFE) begin bad++; $display("FAIL reset anodo: got %h want fe", anodo); end
        total++;
        if (led_reset !== 1'b1) begin bad++; $display("FAIL reset led_reset: got %b want 1", led_reset); end
        total++;
        if (catodo !== seg_tab[0]) begin bad++; $display("FAIL reset catodo: got %b want %b", catodo, seg_tab[0]); end
        tick(2);
        rst_n = 1'b1;
        exp_led = 16'h0000;
        tick(2);
    endtask

    task automatic test_directed();
        logic [7:0] xs [9] = '{8'h04, 8'hFD, 8'h05, 8'h80, 8'h7F, 8'h7F, 8'h00, 8'hFF, 8'h80};
        logic [7:0] ys [9] = '{8'h07, 8'h05, 8'hFD, 8'h80, 8'h80, 8'h7F, 8'hFF, 8'hFF, 8'h7F};
        for (int i = 0; i < 9; i++) do_mult(xs[i], ys[i], "directed");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            do_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
    endtask

    task automatic test_held_button();
        logic [15:0] old;
        old = exp_led;
        a = 8'h03; b = 8'h05;
        pb = 1'b1;
        tick(11);
        total++;
        if (led !== old) begin bad++; $display("FAIL held early: got %h want %h", led, old); end
        tick(1);
        exp_led = ref_mul(8'h03, 8'h05);
        total++;
        if (led !== exp_led) begin bad++; $display("FAIL held product: got %h want %h", led, exp_led); end
        a = 8'h55; b = 8'h66;
        tick(38);
        pb = 1'b0;
        tick(6);
        total++;
        if (led !== exp_led) begin bad++; $display("FAIL held single: got %h want %h", led, exp_led); end
    endtask

    task automatic test_press_during_calc();
        logic [15:0] old;
        old = exp_led;
        a = 8'h09; b = 8'hFA;
        pb = 1'b1;
        tick(1);
        pb = 1'b0;
        tick(3);
        a = 8'h7F; b = 8'h7F;
        pb = 1'b1;
        tick(1);
        pb = 1'b0;
        tick(6);
        total++;
        if (led !== old) begin bad++; $display("FAIL calc-press early: got %h want %h", led, old); end
        tick(1);
        exp_led = ref_mul(8'h09, 8'hFA);
        total++;
        if (led !== exp_led) begin bad++; $display("FAIL calc-press product: got %h want %h", led, exp_led); end
        tick(25);
        total++;
        if (led !== exp_led) begin bad++; $display("FAIL calc-press discarded: got %h want %h", led, exp_led); end
    endtask

    task automatic test_reset_mid_op();
        a = 8'h21; b = 8'h13;
        pb = 1'b1;
        tick(1);
        pb = 1'b0;
        tick(6);
        rst_n = 1'b0;
        #1;
        exp_led = 16'h0000;
        total++;
        if (led !== exp_led) begin bad++; $display("FAIL midreset led: got %h want %h", led, exp_led); end
        total++;
        if (anodo !== 8'hFE) begin bad++; $display("FAIL midreset anodo: got %h want fe", anodo); end
        total++;
        if (led_reset !== 1'b1) begin bad++; $display("FAIL midreset led_reset: got %b want 1", led_reset); end
        tick(2);
        rst_n = 1'b1;
        tick(20);
        total++;
        if (led !== exp_led) begin bad++; $display("FAIL midreset aborted: got %h want %h", led, exp_led); end
        do_mult(8'hE7, 8'h0B, "after-reset");
    endtask

    task automatic test_display();
        logic [7:0] one;
        logic [3:0] dig;
        int         k;
        one = 8'h01;
        do_mult(8'hB5, 8'h49, "display-setup");
        a = 8'h12; b = 8'h34;
        tick(2);
        for (int i = 0; i < 72; i++) begin
            k = (tcount / 4) % 8;
            case (k)
                7: dig = a[7:4];
                6: dig = a[3:0];
                5: dig = b[7:4];
                4: dig = b[3:0];
                3: dig = exp_led[15:12];
                2: dig = exp_led[11:8];
                1: dig = exp_led[7:4];
                default: dig = exp_led[3:0];
            endcase
            total++;
            if (anodo !== ~(one << k)) begin bad++; $display("FAIL scan anodo t=%0d: got %h want %h", tcount, anodo, ~(one << k)); end
            total++;
            if (catodo !== seg_tab[dig]) begin bad++; $display("FAIL scan catodo t=%0d: got %b want %b", tcount, catodo, seg_tab[dig]); end
            tick(1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_held_button();
        test_press_during_calc();
        test_reset_mid_op();
        test_display();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/top.md
Name: top

Overview:
- Board-level top for a signed 8x8 radix-2 Booth multiplier.
- Operands come from switches A and B; a debounced push-button starts one multiplication.
- The 16-bit two's-complement product is shown on LED[15:0].
- Operands and product are also shown in hex on an 8-digit multiplexed seven-segment display.

Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable samples (10 ms at 100 MHz) required to accept a new button level.
- REFRESH_CYCLES, default 100000: clocks each display digit stays lit before the scan advances.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz, all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- A  input  8  multiplicand, signed two's complement.
- B  input  8  multiplier, signed two's complement.
- pb_entrada  input  1  raw start push-button, active-high, asynchronous to the clock.
- LED  output  16  last computed product, signed.
- LED_reset  output  1  high while reset is asserted (equals ~reset, combinational).
- LED_pb  output  1  debounced button level.
- anodo  output  8  digit enables, active-low, one-hot.
- catodo  output  7  segments, active-low; bit0=a ... bit6=g.

Behaviour:
- Reset (reset=0, async) drives:
  - LED=0, LED_pb=0, FSM=IDLE.
  - Debounce and synchronizer state cleared.
  - Scan index 0, anodo=8'b11111110, refresh counter 0.
- Button path: 2-flop synchronizer, then debounce filter, giving LED_pb. The start pulse is one clock wide, on the 0->1 transition of LED_pb. Holding the button produces exactly one pulse.
- FSM states: IDLE, CALC, DONE.
- IDLE, start pulse at edge N:
  - Capture M = A sign-extended to 9 bits, Q = B.
  - Clear Acc (9 bits) and Q_1; count = 0; go to CALC.
  - A and B are ignored after capture.
- CALC, edges N+1..N+8, one iteration per edge:
  - {Q[0],Q_1}=01: Acc += M.
  - {Q[0],Q_1}=10: Acc -= M.
  - 00 or 11: no change.
  - Then arithmetic right shift of {Acc,Q,Q_1} by 1 (Acc MSB replicated).
  - count increments; after the 8th iteration go to DONE.
- DONE, edge N+9: LED <= {Acc[7:0],Q}; return to IDLE.
- LED changes only at the DONE edge and holds between operations.
- Start pulses outside IDLE are discarded, not queued.
- The 9-bit accumulator is mandatory; it makes (-128)x(-128) = 0x4000 exact. All 65536 operand pairs must give the exact signed product.
- Reset mid-operation aborts the operation: LED=0, FSM=IDLE.
- Display scan:
  - The refresh counter wraps at REFRESH_CYCLES-1 and the digit index (0..7) then increments, wrapping 7->0.
  - anodo bit k is low only when index=k.
  - Digit 7..6 = A[7:4], A[3:0]; digit 5..4 = B[7:4], B[3:0] (live switch values); digit 3..0 = LED[15:12] .. LED[3:0].
- Hex encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Display output timing: catodo is registered together with anodo, with no ghosting (both change on the same edge).

Optional Feature:
- Macro DEBOUNCE_EN.
- Defined: the debounce filter described above is instantiated (DEBOUNCE_CYCLES applies).
- Undefined: LED_pb is the synchronizer output directly. The start pulse then comes 2 clocks after the raw rising edge, the parameter is unused, and benches can use 10 ns presses.

Test Plan:
- Basic multiply: reset low then high; A=0x04, B=0x07; one press -> start pulse; LED=0x001C at edge N+9, LED_pb follows the filtered button, LED_reset=0.
- Negative operand: A=0xFD, B=0x05 -> LED=0xFFF1. Then A=0x05, B=0xFD -> LED=0xFFF1.
- Extremes:
  - A=0x80, B=0x80 -> LED=0x4000.
  - A=0x7F, B=0x80 -> LED=0xC080.
  - A=0x7F, B=0x7F -> LED=0x3F01.
  - A=0x00, B=0xFF -> LED=0x0000.
- Held button and ignored presses: button held 50 clocks -> exactly one computation. Press during CALC -> ignored, LED changes once. Changing A mid-CALC does not alter the result.
- Reset mid-operation: assert reset at edge N+4 -> LED=0, anodo=0xFE, LED_reset=1 immediately (async). After release, a new press computes correctly.
- Display scan: with REFRESH_CYCLES=4, A=0x12, B=0x34, LED=0xABCD, digits 7..0 read 1,2,3,4,A,b,C,d. anodo cycles FE, FD, ..., 7F, FE; each digit lasts 4 clocks.
